mdu: RTL and testbench
======================

# mdu

Multiply/divide unit that consumes the two register-file read operands (RData1 → A, RData2 → B) and holds its results in internal HI/LO registers. It performs iterative 32-cycle signed and unsigned multiply and divide, plus direct HI/LO writes. It sits beside the ALU in the execute stage, and the pipeline control stalls on Busy.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- Clk  input  1  single clock, rising-edge active.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- Start  input  1  operation request, sampled at the rising edge.
- Op  input  3  operation code: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- A  input  32  operand 1 (multiplicand / dividend / MTHI-MTLO data).
- B  input  32  operand 2 (multiplier / divisor).
- Busy  output  1  high while a multiply or divide is iterating.
- HI  output  32  HI register (multiply upper word / remainder).
- LO  output  32  LO register (multiply lower word / quotient).

## Operation
- Reset (async, active-high):
  - Busy=0, HI=0, LO=0; iteration counter and working registers cleared.
  - Takes effect without a clock edge, including mid-operation; the in-flight operation is discarded.
- Two states:
  - IDLE (Busy=0).
  - RUN (Busy=1), with a 6-bit counter.
- IDLE, Start=1, Op=MULTU/MULT/DIVU/DIV:
  - On the edge, latch the operands, the signs and the op.
  - For signed ops, latch the absolute values; |−2^31| is taken as 0x8000_0000 unsigned.
  - Load counter=32 and go to RUN.
- IDLE, Start=1, Op=MTHI/MTLO:
  - On the edge, HI←A (or LO←A). Stay in IDLE; Busy never rises.
- IDLE, Start=1, Op=110/111: no state change.
- RUN, multiply: one shift-add step per edge on the unsigned magnitudes, producing a 64-bit product.
- RUN, divide: one restoring shift-subtract step per edge, producing a 32-bit quotient and remainder.
- RUN, final (32nd) edge:
  - Counter reaches 0 and the state returns to IDLE.
  - HI/LO are written with the sign-corrected result on the same edge.
- Sign correction:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
- Divide by zero (DIVU or DIV, B=0):
  - Still runs 32 cycles.
  - Result is LO=0xFFFF_FFFF and HI=A (the original, uncorrected A). No exception.
- DIV overflow (A=0x8000_0000, B=0xFFFF_FFFF): LO=0x8000_0000, HI=0.
- HI/LO hold their previous values for the whole of RUN.
- Start while Busy=1 is ignored, for any Op including MTHI/MTLO. It is not queued and has no effect on the result.
- A and B may change freely after the Start edge, because the operands are latched.

## Timing
- Start accepted at edge T:
  - Busy=1 after edge T.
  - Busy stays high for exactly 32 cycles and falls after edge T+32.
  - HI/LO show the new result after edge T+32.
- A new Start may be accepted at edge T+32+1 at the earliest, i.e. the first edge where Busy=0 is sampled. There is no same-edge back-to-back acceptance.
- MTHI/MTLO at edge T: the new value is visible on HI/LO after edge T; latency 1.
- HI, LO and Busy are registered outputs with no combinational path from the inputs.
- Reset deasserted between edges: the first edge after deassertion operates normally.

## Test plan
- MULTU with A=0xFFFF_FFFF, B=0xFFFF_FFFF:
  - Busy high for exactly 32 cycles.
  - Then HI=0xFFFF_FFFE, LO=0x0000_0001.
- MULT with A=0xFFFF_FFFD (−3), B=5 → HI=0xFFFF_FFFF, LO=0xFFFF_FFF1.
  - Then MULT 0x8000_0000 × 0x8000_0000 → HI=0x4000_0000, LO=0.
- Divides:
  - DIVU 7/2 → LO=3, HI=1.
  - DIV 0xFFFF_FFF9 (−7) / 2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
  - DIV 7 / 0xFFFF_FFFE (−2) → LO=0xFFFF_FFFD, HI=1.
- DIVU 0x1234/0 → LO=0xFFFF_FFFF, HI=0x1234 after 32 cycles.
  - DIV 0x8000_0000/0xFFFF_FFFF → LO=0x8000_0000, HI=0.
- MTHI 0xDEAD_BEEF while idle → HI=0xDEAD_BEEF one cycle later, Busy stays 0.
  - Then MULTU 2×3, and mid-run Start with MTLO A=0x55 and with DIVU → both ignored; final HI=0, LO=6.
- Assert Reset between edges at cycle 10 of a MULT:
  - Busy=0, HI=0, LO=0 immediately, with no clock edge.
  - After release, MULTU 4×4 → LO=16 after 32 cycles.

Source files
------------

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module      : mdu
// Description : Iterative 32-bit multiply/divide unit with HI/LO result
//               registers. Shift-add multiply and restoring divide, both
//               running 32 cycles on operand magnitudes with sign fix-up on
//               the final edge. MTHI/MTLO write HI/LO directly.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] C_OP_MTHI  = 3'b100;
  localparam logic [2:0] C_OP_MTLO  = 3'b101;
  localparam logic [5:0] C_ITERS    = 6'd32;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_cnt;
  logic [31:0] r_a;        // multiplicand magnitude
  logic [31:0] r_b;        // divisor magnitude
  logic [31:0] r_dividend; // raw A, returned as HI on divide by zero
  logic        r_bzero;
  logic        r_is_div;
  logic        r_sa;       // operand signs, forced to 0 for unsigned ops
  logic        r_sb;
  logic [63:0] r_acc;      // mul: {partial product, multiplier}; div: {rem, quo}
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_go;
  logic        w_done;
  logic        w_signed;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_sum;
  logic [32:0] w_diff;
  logic [63:0] w_acc_next;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  // Arithmetic ops are the codes with Op[2] clear; Op[0] selects signed.
  assign w_go     = (r_state == S_IDLE) && Start && !Op[2];
  assign w_done   = (r_state == S_RUN) && (r_cnt == 6'd1);
  assign w_signed = Op[0];
  // Negating 0x8000_0000 yields 0x8000_0000, the correct unsigned magnitude.
  assign w_abs_a  = (w_signed && A[31]) ? (32'd0 - A) : A;
  assign w_abs_b  = (w_signed && B[31]) ? (32'd0 - B) : B;

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  assign w_sum  = {1'b0, r_acc[63:32]} + {1'b0, r_a};
  assign w_diff = r_acc[63:31] - {1'b0, r_b};

  // Select the next accumulator value for the active operation.
  always_comb begin
    w_acc_next = r_acc;
    if (r_is_div) begin
      if (w_diff[32]) w_acc_next = {r_acc[62:0], 1'b0};
      else            w_acc_next = {w_diff[31:0], r_acc[30:0], 1'b1};
    end else begin
      if (r_acc[0]) w_acc_next = {w_sum, r_acc[31:1]};
      else          w_acc_next = {1'b0, r_acc[63:1]};
    end
  end

  // Sign correction of the final magnitude result.
  always_comb begin
    w_prod_fix = w_acc_next;
    w_quo_fix  = w_acc_next[31:0];
    w_rem_fix  = w_acc_next[63:32];
    if (r_sa ^ r_sb) begin
      w_prod_fix = 64'd0 - w_acc_next;
      w_quo_fix  = 32'd0 - w_acc_next[31:0];
    end
    if (r_sa) w_rem_fix = 32'd0 - w_acc_next[63:32];
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: accept an arithmetic op in IDLE, leave RUN after 32 steps.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_go)   w_next = S_RUN;
      S_RUN:   if (w_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch, iteration datapath and HI/LO updates.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt      <= 6'd0;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_dividend <= 32'd0;
      r_bzero    <= 1'b0;
      r_is_div   <= 1'b0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_acc      <= 64'd0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
    end else if (w_go) begin
      r_cnt      <= C_ITERS;
      r_a        <= w_abs_a;
      r_b        <= w_abs_b;
      r_dividend <= A;
      r_bzero    <= (B == 32'd0);
      r_is_div   <= Op[1];
      r_sa       <= w_signed & A[31];
      r_sb       <= w_signed & B[31];
      r_acc      <= Op[1] ? {32'd0, w_abs_a} : {32'd0, w_abs_b};
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt - 6'd1;
      r_acc <= w_acc_next;
      if (w_done) begin
        if (!r_is_div) begin
          r_hi <= w_prod_fix[63:32];
          r_lo <= w_prod_fix[31:0];
        end else if (r_bzero) begin
          r_hi <= r_dividend;
          r_lo <= 32'hFFFF_FFFF;
        end else begin
          r_hi <= w_rem_fix;
          r_lo <= w_quo_fix;
        end
      end
    end else if (Start && (Op == C_OP_MTHI)) begin
      r_hi <= A;
    end else if (Start && (Op == C_OP_MTLO)) begin
      r_lo <= A;
    end
  end

  assign Busy = (r_state == S_RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu
// Description : Directed self-checking bench for mdu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu;

  localparam logic [2:0] C_MULTU = 3'b000;
  localparam logic [2:0] C_MULT  = 3'b001;
  localparam logic [2:0] C_DIVU  = 3'b010;
  localparam logic [2:0] C_DIV   = 3'b011;
  localparam logic [2:0] C_MTHI  = 3'b100;
  localparam logic [2:0] C_MTLO  = 3'b101;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'b000;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int pass_cnt = 0;
  int total_cnt = 0;

  mdu dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Op    (Op),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 Clk = ~Clk;

  // Present one request for a single edge, then scramble the operands.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk);
    #1;
    Start = 1'b0; A = $urandom; B = $urandom;
  endtask

  // Count edges until Busy falls, bounded.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (Busy === 1'b1 && cyc < 64) begin
      @(posedge Clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    #2;
    total_cnt++;
    if ({Busy, HI, LO} !== 65'd0) $display("FAIL reset_hold got busy=%b hi=%h lo=%h want 0/0/0", Busy, HI, LO);
    else pass_cnt++;
    #20 Reset = 1'b0;
    @(posedge Clk); #1;
    total_cnt++;
    if ({Busy, HI, LO} !== 65'd0) $display("FAIL reset_release got busy=%b hi=%h lo=%h want 0/0/0", Busy, HI, LO);
    else pass_cnt++;
  endtask

  task automatic test_multu;
    int cyc;
    issue(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    total_cnt++;
    if (Busy !== 1'b1) $display("FAIL multu_busy_rise got %b want 1", Busy);
    else pass_cnt++;
    wait_idle(cyc);
    total_cnt++;
    if (cyc != 32) $display("FAIL multu_cycles got %0d want 32", cyc);
    else pass_cnt++;
    total_cnt++;
    if ({HI, LO} !== 64'hFFFF_FFFE_0000_0001) $display("FAIL multu_result got %h_%h want fffffffe_00000001", HI, LO);
    else pass_cnt++;
  endtask

  task automatic test_mult;
    int cyc;
    issue(C_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_idle(cyc);
    total_cnt++;
    if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFF1) $display("FAIL mult_neg got %h_%h want ffffffff_fffffff1", HI, LO);
    else pass_cnt++;
    issue(C_MULT, 32'h8000_0000, 32'h8000_0000);
    wait_idle(cyc);
    total_cnt++;
    if ({HI, LO} !== 64'h4000_0000_0000_0000) $display("FAIL mult_minmin got %h_%h want 40000000_00000000", HI, LO);
    else pass_cnt++;
  endtask

  task automatic test_div;
    int cyc;
    issue(C_DIVU, 32'd7, 32'd2);
    wait_idle(cyc);
    total_cnt++;
    if ({HI, LO} !== {32'd1, 32'd3}) $display("FAIL divu_7_2 got hi=%h lo=%h want 1/3", HI, LO);
    else pass_cnt++;
    issue(C_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(cyc);
    total_cnt++;
    if ({HI, LO} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) $display("FAIL div_m7_2 got hi=%h lo=%h want ffffffff/fffffffd", HI, LO);
    else pass_cnt++;
    issue(C_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_idle(cyc);
    total_cnt++;
    if ({HI, LO} !== {32'd1, 32'hFFFF_FFFD}) $display("FAIL div_7_m2 got hi=%h lo=%h want 1/fffffffd", HI, LO);
    else pass_cnt++;
  endtask

  task automatic test_div_special;
    int cyc;
    issue(C_DIVU, 32'h0000_1234, 32'd0);
    wait_idle(cyc);
    total_cnt++;
    if (cyc != 32) $display("FAIL divzero_cycles got %0d want 32", cyc);
    else pass_cnt++;
    total_cnt++;
    if ({HI, LO} !== {32'h0000_1234, 32'hFFFF_FFFF}) $display("FAIL divzero got hi=%h lo=%h want 1234/ffffffff", HI, LO);
    else pass_cnt++;
    issue(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(cyc);
    total_cnt++;
    if ({HI, LO} !== {32'd0, 32'h8000_0000}) $display("FAIL div_overflow got hi=%h lo=%h want 0/80000000", HI, LO);
    else pass_cnt++;
    issue(C_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_idle(cyc);
    total_cnt++;
    if ({HI, LO} !== {32'hFFFF_FFF9, 32'hFFFF_FFFF}) $display("FAIL div_signed_zero got hi=%h lo=%h want fffffff9/ffffffff", HI, LO);
    else pass_cnt++;
  endtask

  task automatic test_mthi_ignore;
    int cyc;
    issue(C_MTHI, 32'hDEAD_BEEF, 32'd0);
    total_cnt++;
    if (HI !== 32'hDEAD_BEEF || Busy !== 1'b0) $display("FAIL mthi got hi=%h busy=%b want deadbeef/0", HI, Busy);
    else pass_cnt++;
    issue(C_MTLO, 32'h0000_1111, 32'd0);
    total_cnt++;
    if (LO !== 32'h0000_1111 || HI !== 32'hDEAD_BEEF) $display("FAIL mtlo got hi=%h lo=%h want deadbeef/1111", HI, LO);
    else pass_cnt++;
    issue(3'b110, 32'h9999_9999, 32'h9999_9999);
    total_cnt++;
    if ({Busy, HI, LO} !== {1'b0, 32'hDEAD_BEEF, 32'h0000_1111}) $display("FAIL nop got busy=%b hi=%h lo=%h want 0/deadbeef/1111", Busy, HI, LO);
    else pass_cnt++;
    issue(C_MULTU, 32'd2, 32'd3);
    repeat (3) @(posedge Clk);
    issue(C_MTLO, 32'h0000_0055, 32'd0);
    total_cnt++;
    if (LO !== 32'h0000_1111) $display("FAIL mtlo_busy got lo=%h want 1111", LO);
    else pass_cnt++;
    repeat (2) @(posedge Clk);
    issue(C_DIVU, 32'd100, 32'd7);
    wait_idle(cyc);
    total_cnt++;
    if ({HI, LO} !== {32'd0, 32'd6}) $display("FAIL multu_ignore got hi=%h lo=%h want 0/6", HI, LO);
    else pass_cnt++;
    @(posedge Clk); #1;
    total_cnt++;
    if (Busy !== 1'b0) $display("FAIL no_queue got busy=%b want 0", Busy);
    else pass_cnt++;
  endtask

  task automatic test_async_reset;
    int cyc;
    issue(C_MULT, 32'hFFFF_FFFD, 32'd5);
    repeat (9) @(posedge Clk);
    #3 Reset = 1'b1;
    #1;
    total_cnt++;
    if ({Busy, HI, LO} !== 65'd0) $display("FAIL async_reset got busy=%b hi=%h lo=%h want 0/0/0", Busy, HI, LO);
    else pass_cnt++;
    #2 Reset = 1'b0;
    issue(C_MULTU, 32'd4, 32'd4);
    wait_idle(cyc);
    total_cnt++;
    if (cyc != 32 || {HI, LO} !== {32'd0, 32'd16}) $display("FAIL after_reset got cyc=%0d hi=%h lo=%h want 32/0/10", cyc, HI, LO);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_special();
    test_mthi_ignore();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
